csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
- CPU-side CSR block: executes Zicsr instructions from the execute stage and owns the `tohost` register (0x51E) that simulation benches poll for pass/fail status.
- Also supplies the read-only cycle and instret counters to software.
- Sits beside the ALU in the execute stage.
- Read data goes to the writeback mux; the `tohost` value is exported for the bench and for debug.

Parameters:
- TOHOST_RESET, 32'h0000_0000, reset value of `tohost` (0 = "test still running").
- COUNTER_WIDTH, 64, width of the cycle and instret counters; legal values 33..64.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- csr_valid  input  1  execute-stage instruction is a CSR op (opcode SYSTEM, funct3 != 0)
- stall  input  1  execute stage held; no state update this cycle
- kill  input  1  execute-stage instruction squashed (branch flush); no state update
- csr_funct3  input  3  instruction funct3
- csr_addr  input  12  instruction bits [31:20]
- csr_uimm  input  5  instruction bits [19:15]; rs1 index or zimm
- rs1_data  input  32  forwarded rs1 value
- instret_pulse  input  1  one instruction retired this cycle
- csr_rdata  output  32  old CSR value, written back to rd
- csr_illegal  output  1  unknown address, or write to a read-only CSR
- tohost  output  32  current `tohost` value

Behaviour:
- Reset values: `tohost` = TOHOST_RESET; cycle = 0; instret = 0 (plus the optional-feature counters). csr_rdata and csr_illegal are combinational and read 0 while csr_valid = 0.
- Commit condition: commit = csr_valid & ~stall & ~kill. CSR state changes only on a clk edge where commit = 1.
- Operand selection: src = rs1_data when funct3[2] = 0; src = zero-extended csr_uimm when funct3[2] = 1.
- Operation by funct3[1:0]:
  - 01: RW — new = src.
  - 10: RS — new = old | src.
  - 11: RC — new = old & ~src.
  - 00: no-op, no write.
- Write suppression: RS/RC with csr_uimm = 0 perform no write and raise no illegal flag, even on read-only CSRs. RW always writes.
- Read timing: csr_rdata = old value, combinational, in the same cycle. Zero added latency; the new value is visible from the next cycle.
- Address map:
  - 0x51E `tohost`: RW.
  - 0xC00 cycle[31:0], 0xC80 cycle[63:32]: RO.
  - 0xC02 instret[31:0], 0xC82 instret[63:32]: RO.
  - 0xB00 / 0xB02 / 0xB80 / 0xB82: RW aliases of the same counters (write replaces the addressed half).
  - High-half registers read as zero-extended when COUNTER_WIDTH < 64.
- Unknown address: csr_rdata = 0; csr_illegal = csr_valid; no state change.
- Writing an RO address: csr_illegal = csr_valid; write dropped; csr_rdata still returns the value.
- cycle increments every clock with rst = 0, including stalled cycles. instret increments on instret_pulse. Both wrap modulo 2^COUNTER_WIDTH with no saturation.
- Simultaneous CSR write and increment to the same counter: the written value wins and the increment that cycle is lost.
- A write to the low half never carries into the high half.
- Reset mid-instruction: rst overrides commit; all state returns to reset values on that edge.
- `tohost` is driven directly from its register (no combinational path from the inputs). A second write overwrites the first.

Optional Feature:
- Macro: CSR_HPM_EN.
- When defined:
  - Adds inputs br_retire (1) and br_mispredict (1).
  - Adds 32-bit RW counters mhpmcounter3 (0xB03, branches retired) and mhpmcounter4 (0xB04, mispredicts), read-only mirrors at 0xC03/0xC04.
  - Both counters reset to 0 and wrap; a CSR write wins over a simultaneous increment.
  - Purpose: measuring branch predictor efficacy under bp_enable.
- When undefined: the ports are absent and those addresses decode as unknown (illegal, read 0).

Decomposition:
- csr_pkg: CSR address localparams (CSR_TOHOST, CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH, CSR_MCYCLE..., CSR_HPM3/4) and funct3 encodings (F3_CSRRW/RS/RC/RWI/RSI/RCI).
- One sub-module: csr_counter. Width-parameterised wrap counter with an inc enable and independent lo/hi write ports; instantiated for cycle, instret and the HPM counters.

Test Plan:
- Reset, then idle 10 cycles → tohost = 0; CSRR 0xC00 returns 10 (±1 for sample edge); csr_illegal = 0.
- CSRRWI 0x51E, zimm = 1 → csr_rdata = 0 that cycle; tohost = 1 from the next cycle; a bench polling tohost reports PASSED.
- CSRRW 0x51E, rs1_data = 0xDEAD_BEEF with stall = 1 for 3 cycles, then kill = 1 → tohost remains 0; the same op repeated without kill → 0xDEAD_BEEF.
- Preset 0x51E = 0xF0; CSRRS rs1_data = 0x0F → 0xFF; then CSRRC rs1_data = 0xF0 → 0x0F; CSRRS with uimm = 0 on 0xC00 → no illegal flag.
- Write 0xB00 = 0xFFFF_FFFF, 0xB80 = 0 → next read of 0xC80 = 1 after wrap; CSRRW 0xC02 → csr_illegal = 1 and instret unchanged; read of 0x123 → rdata 0, illegal 1.
- With CSR_HPM_EN: 5 br_retire pulses, 2 br_mispredict → 0xB03 = 5, 0xB04 = 2; a write to 0xB03 = 100 in the same cycle as br_retire → 100.

Source files
------------

// File: rtl/csr_pkg.sv
// CSR unit shared definitions: CSR addresses, Zicsr funct3 encodings and the
// operation kind carried in funct3[1:0].
package csr_pkg;

  // Simulation mailbox polled by test benches
  localparam logic [11:0] CSR_TOHOST    = 12'h51E;

  // User-level read-only counter views
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // Machine-level writable aliases of the same counters
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  // Branch performance counters (present only with CSR_HPM_EN)
  localparam logic [11:0] CSR_HPM3      = 12'hB03;
  localparam logic [11:0] CSR_HPM4      = 12'hB04;
  localparam logic [11:0] CSR_HPM3_RO   = 12'hC03;
  localparam logic [11:0] CSR_HPM4_RO   = 12'hC04;

  // Zicsr funct3 encodings
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Operation selected by funct3[1:0]; funct3[2] only picks the operand source
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

endpackage

// File: rtl/csr_counter.sv
// Free-running wrap-around counter with an increment enable and separate
// 32-bit write ports for the low and high halves. A write in the same cycle
// as an increment wins and the increment is dropped. Supports WIDTH = 32
// (no high half) or WIDTH in 33..64.
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_nx;

  generate
    if (WIDTH > 32) begin : g_wide
      // Half-word writes keep the other half untouched, so a low write never carries upward
      always_comb begin
        count_nx = count + WIDTH'(1);
        if (wr_lo) begin
          count_nx = {count[WIDTH-1:32], wdata};
        end else if (wr_hi) begin
          count_nx = {wdata[WIDTH-33:0], count[31:0]};
        end else if (!inc) begin
          count_nx = count;
        end
      end
    end else begin : g_narrow
      // Single-word counter; a high-half write has nothing to update but still drops the increment
      always_comb begin
        count_nx = count + WIDTH'(1);
        if (wr_lo) begin
          count_nx = wdata;
        end else if (wr_hi || !inc) begin
          count_nx = count;
        end
      end
    end
  endgenerate

  // Counter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nx;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Execute-stage CSR unit: decodes Zicsr operations, returns the old CSR value
// combinationally for writeback, and owns tohost plus the cycle/instret
// counters. Define CSR_HPM_EN to add the branch-retired and mispredict
// performance counters (mhpmcounter3/4) and their br_retire/br_mispredict inputs.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] TOHOST_RESET  = 32'h0000_0000,
  parameter int          COUNTER_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic        stall,
  input  logic        kill,
  input  logic [2:0]  csr_funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  csr_uimm,
  input  logic [31:0] rs1_data,
  input  logic        instret_pulse,
`ifdef CSR_HPM_EN
  input  logic        br_retire,
  input  logic        br_mispredict,
`endif
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [31:0] tohost
);

  csr_op_e                  op;
  logic                     commit;
  logic [31:0]              src;
  logic [31:0]              old_val;
  logic [31:0]              new_val;
  logic                     known;
  logic                     writable;
  logic                     wr_req;
  logic                     do_write;

  logic [COUNTER_WIDTH-1:0] cycle_cnt;
  logic [COUNTER_WIDTH-1:0] instret_cnt;
  logic [63:0]              cycle_ext;
  logic [63:0]              instret_ext;

  assign op     = csr_op_e'(csr_funct3[1:0]);
  assign commit = csr_valid & ~stall & ~kill;
  assign src    = csr_funct3[2] ? {27'd0, csr_uimm} : rs1_data;

  // RS/RC with a zero rs1 index / zimm is a pure read and must not count as a write
  assign wr_req = (op == OP_RW) ||
                  (((op == OP_RS) || (op == OP_RC)) && (csr_uimm != 5'd0));

  // Zero-extend so the high-half views read cleanly for narrow counters
  assign cycle_ext   = 64'(cycle_cnt);
  assign instret_ext = 64'(instret_cnt);

`ifdef CSR_HPM_EN
  logic [31:0] hpm3_cnt;
  logic [31:0] hpm4_cnt;
`endif

  // Address decode: old value, whether the address exists, whether it accepts writes
  always_comb begin
    old_val  = 32'd0;
    known    = 1'b0;
    writable = 1'b0;
    case (csr_addr)
      CSR_TOHOST:    begin old_val = tohost;             known = 1'b1; writable = 1'b1; end
      CSR_CYCLE:     begin old_val = cycle_ext[31:0];    known = 1'b1; end
      CSR_CYCLEH:    begin old_val = cycle_ext[63:32];   known = 1'b1; end
      CSR_INSTRET:   begin old_val = instret_ext[31:0];  known = 1'b1; end
      CSR_INSTRETH:  begin old_val = instret_ext[63:32]; known = 1'b1; end
      CSR_MCYCLE:    begin old_val = cycle_ext[31:0];    known = 1'b1; writable = 1'b1; end
      CSR_MCYCLEH:   begin old_val = cycle_ext[63:32];   known = 1'b1; writable = 1'b1; end
      CSR_MINSTRET:  begin old_val = instret_ext[31:0];  known = 1'b1; writable = 1'b1; end
      CSR_MINSTRETH: begin old_val = instret_ext[63:32]; known = 1'b1; writable = 1'b1; end
`ifdef CSR_HPM_EN
      CSR_HPM3:      begin old_val = hpm3_cnt;           known = 1'b1; writable = 1'b1; end
      CSR_HPM4:      begin old_val = hpm4_cnt;           known = 1'b1; writable = 1'b1; end
      CSR_HPM3_RO:   begin old_val = hpm3_cnt;           known = 1'b1; end
      CSR_HPM4_RO:   begin old_val = hpm4_cnt;           known = 1'b1; end
`endif
      default:       begin old_val = 32'd0;              known = 1'b0; end
    endcase
  end

  // Read-modify-write result for the selected operation
  always_comb begin
    new_val = old_val;
    case (op)
      OP_RW:   new_val = src;
      OP_RS:   new_val = old_val | src;
      OP_RC:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  assign do_write    = commit & known & writable & wr_req;
  assign csr_rdata   = (csr_valid && known) ? old_val : 32'd0;
  assign csr_illegal = csr_valid & (~known | (wr_req & ~writable));

  // tohost mailbox register; output comes straight from the flop
  always_ff @(posedge clk) begin
    if (rst) begin
      tohost <= TOHOST_RESET;
    end else if (do_write && (csr_addr == CSR_TOHOST)) begin
      tohost <= new_val;
    end
  end

  csr_counter #(
    .WIDTH (COUNTER_WIDTH)
  ) u_cycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (do_write && (csr_addr == CSR_MCYCLE)),
    .wr_hi (do_write && (csr_addr == CSR_MCYCLEH)),
    .wdata (new_val),
    .count (cycle_cnt)
  );

  csr_counter #(
    .WIDTH (COUNTER_WIDTH)
  ) u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret_pulse),
    .wr_lo (do_write && (csr_addr == CSR_MINSTRET)),
    .wr_hi (do_write && (csr_addr == CSR_MINSTRETH)),
    .wdata (new_val),
    .count (instret_cnt)
  );

`ifdef CSR_HPM_EN
  csr_counter #(
    .WIDTH (32)
  ) u_hpm3 (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_retire),
    .wr_lo (do_write && (csr_addr == CSR_HPM3)),
    .wr_hi (1'b0),
    .wdata (new_val),
    .count (hpm3_cnt)
  );

  csr_counter #(
    .WIDTH (32)
  ) u_hpm4 (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_mispredict),
    .wr_lo (do_write && (csr_addr == CSR_HPM4)),
    .wr_hi (1'b0),
    .wdata (new_val),
    .count (hpm4_cnt)
  );
`endif

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: a table of per-cycle vectors driven on the falling edge,
// expectations pushed to a scoreboard queue and popped when outputs settle.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_valid = 1'b0;
  logic        stall = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  csr_funct3 = 3'd0;
  logic [11:0] csr_addr = 12'd0;
  logic [4:0]  csr_uimm = 5'd0;
  logic [31:0] rs1_data = 32'd0;
  logic        instret_pulse = 1'b0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] tohost;
`ifdef CSR_HPM_EN
  logic        br_retire = 1'b0;
  logic        br_mispredict = 1'b0;
`endif

  always #5 clk = ~clk;

  csr_unit dut (
    .clk           (clk),
    .rst           (rst),
    .csr_valid     (csr_valid),
    .stall         (stall),
    .kill          (kill),
    .csr_funct3    (csr_funct3),
    .csr_addr      (csr_addr),
    .csr_uimm      (csr_uimm),
    .rs1_data      (rs1_data),
    .instret_pulse (instret_pulse),
`ifdef CSR_HPM_EN
    .br_retire     (br_retire),
    .br_mispredict (br_mispredict),
`endif
    .csr_rdata     (csr_rdata),
    .csr_illegal   (csr_illegal),
    .tohost        (tohost)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  uimm;
    logic [31:0] rs1;
    logic        stall;
    logic        kill;
    logic        pulse;
    logic [1:0]  br;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_ill;
    logic [31:0] exp_th;
  } vec_t;

  typedef struct {
    int          idx;
    logic        chk_rd;
    logic [31:0] rd;
    logic        ill;
    logic [31:0] th;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   checks = 0;

  task automatic add(input logic r, input logic v, input logic [2:0] f3,
                     input logic [11:0] a, input logic [4:0] u, input logic [31:0] d,
                     input logic s, input logic k, input logic p, input logic [1:0] b,
                     input logic c, input logic [31:0] rd, input logic il,
                     input logic [31:0] th);
    vec_t x;
    x.rst = r; x.valid = v; x.f3 = f3; x.addr = a; x.uimm = u; x.rs1 = d;
    x.stall = s; x.kill = k; x.pulse = p; x.br = b;
    x.chk_rd = c; x.exp_rd = rd; x.exp_ill = il; x.exp_th = th;
    vecs.push_back(x);
  endtask

  // CSRR: csrrs with rs1 = x0; rs1_data is junk to show the write is suppressed
  task automatic rd_op(input logic [11:0] a, input logic [31:0] rd, input logic il,
                       input logic [31:0] th);
    add(1'b0, 1'b1, F3_CSRRS, a, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 2'b00,
        1'b1, rd, il, th);
  endtask

  task automatic wr_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] u,
                       input logic [31:0] d, input logic [31:0] rd, input logic il,
                       input logic [31:0] th);
    add(1'b0, 1'b1, f3, a, u, d, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, rd, il, th);
  endtask

  task automatic idle(input logic r, input logic [31:0] th);
    add(r, 1'b0, 3'd0, 12'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'd0, 1'b0, th);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL v%0d %s: got %h, expected %h", idx, name, act, req);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    rst           = v.rst;
    csr_valid     = v.valid;
    csr_funct3    = v.f3;
    csr_addr      = v.addr;
    csr_uimm      = v.uimm;
    rs1_data      = v.rs1;
    stall         = v.stall;
    kill          = v.kill;
    instret_pulse = v.pulse;
`ifdef CSR_HPM_EN
    br_retire     = v.br[0];
    br_mispredict = v.br[1];
`endif
    e = '{idx: idx, chk_rd: v.chk_rd, rd: v.exp_rd, ill: v.exp_ill, th: v.exp_th};
    sb.push_back(e);
    #2;
    vectors++;
    if (sb.size() == 0) begin
      checks++;
      miscompares++;
      $display("FAIL v%0d scoreboard: got empty queue, expected an entry", idx);
    end else begin
      e = sb.pop_front();
      if (e.chk_rd) check("csr_rdata", e.idx, csr_rdata, e.rd);
      check("csr_illegal", e.idx, {31'd0, csr_illegal}, {31'd0, e.ill});
      check("tohost", e.idx, tohost, e.th);
    end
  endtask

  initial begin
    // Reset, then 10 idle cycles; main vector j samples with cycle = 10 + j
    idle(1'b1, 32'd0);
    for (int i = 0; i < 10; i++) idle(1'b0, 32'd0);

    rd_op(CSR_CYCLE, 32'd10, 1'b0, 32'd0);                                   // 0
    wr_op(F3_CSRRWI, CSR_TOHOST, 5'd1, 32'd0, 32'd0, 1'b0, 32'd0);           // 1
    wr_op(F3_CSRRW, CSR_TOHOST, 5'd3, 32'd0, 32'd1, 1'b0, 32'd1);            // 2
    for (int i = 0; i < 3; i++)                                              // 3..5 stalled
      add(1'b0, 1'b1, F3_CSRRW, CSR_TOHOST, 5'd4, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 2'b00,
          1'b1, 32'd0, 1'b0, 32'd0);
    add(1'b0, 1'b1, F3_CSRRW, CSR_TOHOST, 5'd4, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 2'b00,
        1'b1, 32'd0, 1'b0, 32'd0);                                           // 6 killed
    wr_op(F3_CSRRW, CSR_TOHOST, 5'd4, 32'hDEAD_BEEF, 32'd0, 1'b0, 32'd0);    // 7
    rd_op(CSR_TOHOST, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);                   // 8
    wr_op(F3_CSRRW, CSR_TOHOST, 5'd1, 32'hF0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF); // 9
    wr_op(F3_CSRRS, CSR_TOHOST, 5'd1, 32'h0F, 32'hF0, 1'b0, 32'hF0);         // 10
    wr_op(F3_CSRRC, CSR_TOHOST, 5'd2, 32'hF0, 32'hFF, 1'b0, 32'hFF);         // 11
    rd_op(CSR_TOHOST, 32'h0F, 1'b0, 32'h0F);                                 // 12
    rd_op(CSR_CYCLE, 32'd23, 1'b0, 32'h0F);                                  // 13
    wr_op(F3_CSRRCI, CSR_CYCLEH, 5'd0, 32'd0, 32'd0, 1'b0, 32'h0F);          // 14
    wr_op(F3_CSRRW, CSR_INSTRET, 5'd1, 32'h1234, 32'd0, 1'b1, 32'h0F);       // 15
    rd_op(CSR_INSTRET, 32'd0, 1'b0, 32'h0F);                                 // 16
    wr_op(F3_CSRRSI, CSR_CYCLE, 5'd1, 32'd0, 32'd27, 1'b1, 32'h0F);          // 17
    rd_op(12'h123, 32'd0, 1'b1, 32'h0F);                                     // 18
    wr_op(F3_CSRRW, 12'h123, 5'd1, 32'h55, 32'd0, 1'b1, 32'h0F);             // 19
    add(1'b0, 1'b0, F3_CSRRW, CSR_TOHOST, 5'd1, 32'h77, 1'b0, 1'b0, 1'b1, 2'b00,
        1'b1, 32'd0, 1'b0, 32'h0F);                                          // 20
    add(1'b0, 1'b1, F3_CSRRS, CSR_INSTRET, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 2'b00,
        1'b1, 32'd1, 1'b0, 32'h0F);                                          // 21
    add(1'b0, 1'b1, F3_CSRRW, CSR_MINSTRET, 5'd1, 32'd100, 1'b0, 1'b0, 1'b1, 2'b00,
        1'b1, 32'd2, 1'b0, 32'h0F);                                          // 22 write beats pulse
    rd_op(CSR_INSTRET, 32'd100, 1'b0, 32'h0F);                               // 23
    rd_op(CSR_INSTRETH, 32'd0, 1'b0, 32'h0F);                                // 24
    rd_op(CSR_TOHOST, 32'h0F, 1'b0, 32'h0F);                                 // 25
    wr_op(F3_CSRRW, CSR_MCYCLEH, 5'd1, 32'd0, 32'd0, 1'b0, 32'h0F);          // 26
    add(1'b0, 1'b1, F3_CSRRW, CSR_MCYCLE, 5'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 2'b00,
        1'b0, 32'd0, 1'b0, 32'h0F);                                          // 27
    rd_op(CSR_CYCLE, 32'hFFFF_FFFF, 1'b0, 32'h0F);                           // 28
    rd_op(CSR_CYCLEH, 32'd1, 1'b0, 32'h0F);                                  // 29
    rd_op(CSR_CYCLE, 32'd1, 1'b0, 32'h0F);                                   // 30
    wr_op(F3_CSRRW, CSR_MCYCLEH, 5'd1, 32'd5, 32'd1, 1'b0, 32'h0F);          // 31
    rd_op(CSR_CYCLEH, 32'd5, 1'b0, 32'h0F);                                  // 32
    rd_op(CSR_MINSTRETH, 32'd0, 1'b0, 32'h0F);                               // 33
`ifdef CSR_HPM_EN
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b0, 3'd0, 12'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, (i < 2) ? 2'b11 : 2'b01,
          1'b1, 32'd0, 1'b0, 32'h0F);
    rd_op(CSR_HPM3, 32'd5, 1'b0, 32'h0F);
    rd_op(CSR_HPM4, 32'd2, 1'b0, 32'h0F);
    wr_op(F3_CSRRW, CSR_HPM3_RO, 5'd1, 32'd9, 32'd5, 1'b1, 32'h0F);
    add(1'b0, 1'b1, F3_CSRRW, CSR_HPM3, 5'd1, 32'd100, 1'b0, 1'b0, 1'b0, 2'b01,
        1'b1, 32'd5, 1'b0, 32'h0F);
    rd_op(CSR_HPM3, 32'd100, 1'b0, 32'h0F);
    rd_op(CSR_HPM4_RO, 32'd2, 1'b0, 32'h0F);
`else
    rd_op(CSR_HPM3, 32'd0, 1'b1, 32'h0F);
    wr_op(F3_CSRRW, CSR_HPM4_RO, 5'd1, 32'd9, 32'd0, 1'b1, 32'h0F);
`endif
    // Reset arriving with a committing write: reset wins
    add(1'b1, 1'b1, F3_CSRRW, CSR_TOHOST, 5'd1, 32'hAAAA_5555, 1'b0, 1'b0, 1'b1, 2'b00,
        1'b1, 32'h0F, 1'b0, 32'h0F);
    rd_op(CSR_TOHOST, 32'd0, 1'b0, 32'd0);
    rd_op(CSR_CYCLE, 32'd1, 1'b0, 32'd0);
    rd_op(CSR_INSTRET, 32'd0, 1'b0, 32'd0);
    rd_op(CSR_CYCLEH, 32'd0, 1'b0, 32'd0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    @(negedge clk);
    csr_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
